// File: rtl/bcd2seg_mux_if.sv
// bcd2seg_mux_if: load/digit inputs and segment/anode/error outputs of the
// two-digit multiplexed 7-segment driver.
interface bcd2seg_mux_if;
    logic       load;
    logic [3:0] uni;
    logic [3:0] dec;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    modport master (output load, output uni, output dec,
                    input  seg,  input  an,  input  err);
    modport slave  (input  load, input  uni, input  dec,
                    output seg,  output an,  output err);
endinterface

// File: rtl/bcd2seg_mux.sv
// bcd2seg_mux: latches a two-digit BCD value and scans it onto a multiplexed
// 7-segment display with a programmable dwell time and an inter-digit
// blanking gap. Optional macro LEADING_ZERO_BLANK_EN darkens a tens digit of 0.
module bcd2seg_mux #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    bcd2seg_mux_if.slave  bus
);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam bit               HAS_BLANK  = (BLANK_CYC != 0);

    typedef enum logic [1:0] {
        U_ON  = 2'd0,
        BLK_U = 2'd1,
        T_ON  = 2'd2,
        BLK_T = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             run;
    logic [3:0]       uni_q, dec_q;
    logic [6:0]       seg_q, seg_nx;
    logic [1:0]       an_q, an_nx;
    logic             err_q;

    // BCD digit to gfedcba segment pattern; non-BCD shows a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Next state/counter; the first edge after reset enters U_ON without advancing
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        if (!run) begin
            state_nx = U_ON;
            cnt_nx   = '0;
        end else begin
            case (state)
                U_ON: if (cnt == SCAN_LAST) begin
                    state_nx = HAS_BLANK ? BLK_U : T_ON;
                    cnt_nx   = '0;
                end
                BLK_U: if (cnt == BLANK_LAST) begin
                    state_nx = T_ON;
                    cnt_nx   = '0;
                end
                T_ON: if (cnt == SCAN_LAST) begin
                    state_nx = HAS_BLANK ? BLK_T : U_ON;
                    cnt_nx   = '0;
                end
                BLK_T: if (cnt == BLANK_LAST) begin
                    state_nx = U_ON;
                    cnt_nx   = '0;
                end
                default: begin
                    state_nx = U_ON;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Output decode for the state being entered, using the currently latched digits
    always_comb begin
        an_nx  = 2'b00;
        seg_nx = 7'h00;
        case (state_nx)
            U_ON: begin
                an_nx  = 2'b01;
                seg_nx = seg_decode(uni_q);
            end
            T_ON: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (dec_q != 4'd0) begin
                    an_nx  = 2'b10;
                    seg_nx = seg_decode(dec_q);
                end
`else
                an_nx  = 2'b10;
                seg_nx = seg_decode(dec_q);
`endif
            end
            default: begin
                an_nx  = 2'b00;
                seg_nx = 7'h00;
            end
        endcase
    end

    // State, counter, digit latches and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= U_ON;
            cnt   <= '0;
            run   <= 1'b0;
            uni_q <= 4'd0;
            dec_q <= 4'd0;
            seg_q <= 7'h00;
            an_q  <= 2'b00;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            run   <= 1'b1;
            seg_q <= seg_nx;
            an_q  <= an_nx;
            err_q <= (uni_q > 4'd9) | (dec_q > 4'd9);
            if (bus.load) begin
                uni_q <= bus.uni;
                dec_q <= bus.dec;
            end
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_bcd2seg_mux.sv
// tb_bcd2seg_mux: directed vectors for bcd2seg_mux with SCAN_DIV=4, run
// side by side with BLANK_CYC=2 (dut_a) and BLANK_CYC=0 (dut_b).
module tb_bcd2seg_mux;

    typedef struct {
        logic [3:0] uni;
        logic [3:0] dec;
        logic [6:0] seg_u;
        logic [6:0] seg_t;
        logic       err;
    } vec_t;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
    } pat_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   k;
    vec_t cur;
    vec_t vecs [9];
    pat_t pat  [12];

    bcd2seg_mux_if ifa ();
    bcd2seg_mux_if ifb ();

    bcd2seg_mux #(.SCAN_DIV(4), .BLANK_CYC(2), .CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    bcd2seg_mux #(.SCAN_DIV(4), .BLANK_CYC(0), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (k=%0d): got %h, expected %h", name, k, act, exp);
        end
    endtask

    // Expected display for the current cycle given a period of 8 + 2*blank
    task automatic expect_out(input int blank, output logic [1:0] ean, output logic [6:0] eseg);
        int p;
        p = (k - 1) % (8 + 2 * blank);
        ean  = 2'b00;
        eseg = 7'h00;
        if (p < 4) begin
            ean  = 2'b01;
            eseg = cur.seg_u;
        end else if (p >= 4 + blank && p < 8 + blank) begin
            ean  = 2'b10;
            eseg = cur.seg_t;
`ifdef LEADING_ZERO_BLANK_EN
            if (cur.dec == 4'd0) begin
                ean  = 2'b00;
                eseg = 7'h00;
            end
`endif
        end
    endtask

    // One clock edge, optionally loading v, then compare both DUTs
    task automatic step(input bit ld, input vec_t v);
        logic [1:0] ean;
        logic [6:0] eseg;
        ifa.load = ld; ifa.uni = v.uni; ifa.dec = v.dec;
        ifb.load = ld; ifb.uni = v.uni; ifb.dec = v.dec;
        @(posedge clk);
        #1;
        k++;
        expect_out(2, ean, eseg);
        chk("a_an",  8'(ifa.an),  8'(ean));
        chk("a_seg", 8'(ifa.seg), 8'(eseg));
        chk("a_err", 8'(ifa.err), 8'(cur.err));
        expect_out(0, ean, eseg);
        chk("b_an",  8'(ifb.an),  8'(ean));
        chk("b_seg", 8'(ifb.seg), 8'(eseg));
        chk("b_err", 8'(ifb.err), 8'(cur.err));
        if (ld) cur = v;
        ifa.load = 1'b0;
        ifb.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, cur);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rst_a_an"},  8'(ifa.an),  8'h00);
        chk({tag, "_rst_a_seg"}, 8'(ifa.seg), 8'h00);
        chk({tag, "_rst_a_err"}, 8'(ifa.err), 8'h00);
        chk({tag, "_rst_b_an"},  8'(ifb.an),  8'h00);
        chk({tag, "_rst_b_seg"}, 8'(ifb.seg), 8'h00);
        chk({tag, "_rst_b_err"}, 8'(ifb.err), 8'h00);
    endtask

    initial begin
        vec_t v2;
        n_cmp = 0;
        n_err = 0;
        k     = 0;
        cur   = '{uni: 4'd0, dec: 4'd0, seg_u: 7'h3F, seg_t: 7'h3F, err: 1'b0};

        vecs[0] = '{uni: 4'd7,  dec: 4'd4,  seg_u: 7'h07, seg_t: 7'h66, err: 1'b0};
        vecs[1] = '{uni: 4'd12, dec: 4'd3,  seg_u: 7'h40, seg_t: 7'h4F, err: 1'b1};
        vecs[2] = '{uni: 4'd1,  dec: 4'd3,  seg_u: 7'h06, seg_t: 7'h4F, err: 1'b0};
        vecs[3] = '{uni: 4'd9,  dec: 4'd6,  seg_u: 7'h6F, seg_t: 7'h7D, err: 1'b0};
        vecs[4] = '{uni: 4'd5,  dec: 4'd8,  seg_u: 7'h6D, seg_t: 7'h7F, err: 1'b0};
        vecs[5] = '{uni: 4'd5,  dec: 4'd0,  seg_u: 7'h6D, seg_t: 7'h3F, err: 1'b0};
        vecs[6] = '{uni: 4'd0,  dec: 4'd15, seg_u: 7'h3F, seg_t: 7'h40, err: 1'b1};
        vecs[7] = '{uni: 4'd8,  dec: 4'd2,  seg_u: 7'h7F, seg_t: 7'h5B, err: 1'b0};
        vecs[8] = '{uni: 4'd14, dec: 4'd13, seg_u: 7'h40, seg_t: 7'h40, err: 1'b1};

        for (int i = 0; i < 12; i++) begin
            if (i < 4)       pat[i] = '{an: 2'b01, seg: 7'h07};
            else if (i < 6)  pat[i] = '{an: 2'b00, seg: 7'h00};
            else if (i < 10) pat[i] = '{an: 2'b10, seg: 7'h66};
            else             pat[i] = '{an: 2'b00, seg: 7'h00};
        end

        rst = 1'b0;
        ifa.load = 1'b0; ifa.uni = 4'd0; ifa.dec = 4'd0;
        ifb.load = 1'b0; ifb.uni = 4'd0; ifb.dec = 4'd0;
        #2;
        reset_checks("init");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 7/4 scan pattern against the hand table
        step(1'b1, vecs[0]);
        while (k % 12 != 0) step(1'b0, cur);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, cur);
            chk("pat_an",  8'(ifa.an),  8'(pat[i].an));
            chk("pat_seg", 8'(ifa.seg), 8'(pat[i].seg));
        end

        // non-BCD units then recovery
        step(1'b1, vecs[1]);
        chk("err_set", 8'(ifa.err), 8'h00);
        step(1'b0, cur);
        chk("err_set_next", 8'(ifa.err), 8'h01);
        idle(11);
        step(1'b1, vecs[2]);
        step(1'b0, cur);
        chk("err_clr", 8'(ifa.err), 8'h00);
        idle(11);

        // load 2 on the second cycle of U_ON with 9 latched
        step(1'b1, vecs[3]);
        while (k % 12 != 0) step(1'b0, cur);
        step(1'b0, cur);
        v2 = '{uni: 4'd2, dec: 4'd6, seg_u: 7'h5B, seg_t: 7'h7D, err: 1'b0};
        step(1'b1, v2);
        chk("mid_load_old", 8'(ifa.seg), 8'h6F);
        step(1'b0, cur);
        chk("mid_load_new", 8'(ifa.seg), 8'h5B);
        step(1'b0, cur);
        chk("mid_load_still_u", 8'(ifa.an), 8'h01);
        step(1'b0, cur);
        chk("mid_load_u_end", 8'(ifa.an), 8'h00);
        idle(7);

        // async reset in the middle of T_ON with err set
        step(1'b1, vecs[1]);
        while (k % 12 != 6) step(1'b0, cur);
        idle(2);
        chk("pre_rst_err", 8'(ifa.err), 8'h01);
        rst = 1'b0;
        #1;
        reset_checks("mid");
        #2;
        rst = 1'b1;
        k   = 0;
        cur = '{uni: 4'd0, dec: 4'd0, seg_u: 7'h3F, seg_t: 7'h3F, err: 1'b0};
        step(1'b0, cur);
        chk("post_rst_an",  8'(ifa.an),  8'h01);
        chk("post_rst_seg", 8'(ifa.seg), 8'h3F);
        idle(3);
        chk("post_rst_u4", 8'(ifa.an), 8'h01);
        step(1'b0, cur);
        chk("post_rst_u5", 8'(ifa.an), 8'h00);
        idle(7);

        // 5/8 on both builds, then leading-zero tens
        step(1'b1, vecs[4]);
        idle(23);
        step(1'b1, vecs[5]);
        idle(23);

        for (int i = 6; i < 9; i++) begin
            step(1'b1, vecs[i]);
            idle(12);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
